// File: rtl/arm_alu_scheduler.sv
// Round-robin scheduler sharing one ARM data-processing ALU between two requesters.
// Holds registered operands and results, and owns the architectural NZCV flag register.
module arm_alu (
   input  logic [31:0] regA,
   input  logic [31:0] regB,
   input  logic [3:0]  A,
   input  logic        C_in,
   output logic [31:0] Y,
   output logic        N,
   output logic        Z,
   output logic        C,
   output logic        V
);
   logic [31:0] add_x;
   logic [31:0] add_y;
   logic        add_ci;
   logic        arith;
   logic [32:0] sum;

   always_comb begin
      add_x  = regA;
      add_y  = regB;
      add_ci = 1'b0;
      arith  = 1'b1;
      // Subtractions are x + ~y + carry, so C comes out as ARM's "no borrow"
      case (A)
         4'b0010, 4'b1010: begin add_y = ~regB; add_ci = 1'b1; end
         4'b0011:          begin add_x = regB; add_y = ~regA; add_ci = 1'b1; end
         4'b0100, 4'b1011: begin add_ci = 1'b0; end
         4'b0101:          begin add_ci = C_in; end
         4'b0110:          begin add_y = ~regB; add_ci = C_in; end
         4'b0111:          begin add_x = regB; add_y = ~regA; add_ci = C_in; end
         default:          begin arith = 1'b0; end
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_ci};
      case (A)
         4'b0000, 4'b1000: Y = regA & regB;
         4'b0001, 4'b1001: Y = regA ^ regB;
         4'b1100:          Y = regA | regB;
         4'b1101:          Y = regB;
         4'b1110:          Y = regA & ~regB;
         4'b1111:          Y = ~regB;
         default:          Y = sum[31:0];
      endcase
      N = Y[31];
      Z = (Y == 32'b0);
      // Logical ops pass the incoming carry through and clear V
      C = arith ? sum[32] : C_in;
      V = arith & (add_x[31] == add_y[31]) & (sum[31] != add_x[31]);
   end
endmodule

module arm_alu_scheduler #(
   parameter logic [3:0] FLAG_INIT = 4'b0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req1_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req0_op,
   input  logic [3:0]  req1_op,
   input  logic        req0_s,
   input  logic        req1_s,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_y,
   output logic [3:0]  rsp_nzcv,
   output logic [3:0]  flags_nzcv,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [3:0]  op_code_q, op_code_d;
   logic        op_s_q, op_s_d;
   logic        op_id_q, op_id_d;
   logic [31:0] rsp_y_q, rsp_y_d;
   logic [3:0]  rsp_nzcv_q, rsp_nzcv_d;
   logic        rsp_id_q, rsp_id_d;
   logic [3:0]  flags_q, flags_d;

   logic        any_req;
   logic        gnt_idx;
   logic        grant_en;
   logic [31:0] alu_y;
   logic [3:0]  alu_nzcv;

   assign any_req = |req_valid;
   assign gnt_idx = (req_valid == 2'b11) ? ~last_q : req_valid[1];

   arm_alu u_alu (
      .regA (op_a_q),
      .regB (op_b_q),
      .A    (op_code_q),
      .C_in (flags_q[1]),
      .Y    (alu_y),
      .N    (alu_nzcv[3]),
      .Z    (alu_nzcv[2]),
      .C    (alu_nzcv[1]),
      .V    (alu_nzcv[0])
   );

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_code_d  = op_code_q;
      op_s_d     = op_s_q;
      op_id_d    = op_id_q;
      rsp_y_d    = rsp_y_q;
      rsp_nzcv_d = rsp_nzcv_q;
      rsp_id_d   = rsp_id_q;
      flags_d    = flags_q;
      grant_en   = 1'b0;
      req_ready  = 2'b00;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_en = 1'b1;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            rsp_y_d    = alu_y;
            rsp_nzcv_d = alu_nzcv;
            rsp_id_d   = op_id_q;
            if (op_s_q) flags_d = alu_nzcv;
            state_d    = DONE;
         end
         DONE: begin
            // A new grant is only taken when the held result is consumed
            if (rsp_ready) begin
               if (any_req) begin
                  grant_en = 1'b1;
                  state_d  = EXEC;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant_en) begin
         req_ready = gnt_idx ? 2'b10 : 2'b01;
         last_d    = gnt_idx;
         op_a_d    = gnt_idx ? req1_a  : req0_a;
         op_b_d    = gnt_idx ? req1_b  : req0_b;
         op_code_d = gnt_idx ? req1_op : req0_op;
         op_s_d    = gnt_idx ? req1_s  : req0_s;
         op_id_d   = gnt_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         op_a_q     <= 32'b0;
         op_b_q     <= 32'b0;
         op_code_q  <= 4'b0;
         op_s_q     <= 1'b0;
         op_id_q    <= 1'b0;
         rsp_y_q    <= 32'b0;
         rsp_nzcv_q <= 4'b0;
         rsp_id_q   <= 1'b0;
         flags_q    <= FLAG_INIT;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_code_q  <= op_code_d;
         op_s_q     <= op_s_d;
         op_id_q    <= op_id_d;
         rsp_y_q    <= rsp_y_d;
         rsp_nzcv_q <= rsp_nzcv_d;
         rsp_id_q   <= rsp_id_d;
         flags_q    <= flags_d;
      end
   end

   assign rsp_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign rsp_y      = rsp_y_q;
   assign rsp_nzcv   = rsp_nzcv_q;
   assign rsp_id     = rsp_id_q;
   assign flags_nzcv = flags_q;
endmodule

// File: tb/tb_arm_alu_scheduler.sv
// Self-checking bench for arm_alu_scheduler: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration, latency and ALU results.
module tb_arm_alu_scheduler;
   localparam logic [3:0] FLAG_INIT = 4'b0000;
   localparam longint TWO32 = 64'sh1_0000_0000;
   localparam longint SMAX  = 64'sh7FFF_FFFF;
   localparam longint SMIN  = -64'sh8000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid, req_ready;
   logic [31:0] req0_a, req1_a, req0_b, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        req0_s, req1_s;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [31:0] rsp_y;
   logic [3:0]  rsp_nzcv, flags_nzcv;

   int   checks = 0;
   int   failures = 0;
   logic [3:0] m_flags;
   logic       m_last;

   arm_alu_scheduler #(.FLAG_INIT(FLAG_INIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op), .req0_s(req0_s), .req1_s(req1_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .rsp_nzcv(rsp_nzcv), .flags_nzcv(flags_nzcv), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference ALU: plain 64-bit integer arithmetic, returns {N,Z,C,V,Y}
   function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
      longint ua, ub, sa, sb, us, ss, ci;
      logic [31:0] y;
      logic c, v;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ci = cin ? 64'sd1 : 64'sd0;
      c = cin; v = 1'b0; y = 32'h0; us = 0; ss = 0;
      case (op)
         4'h0, 4'h8: y = a & b;
         4'h1, 4'h9: y = a ^ b;
         4'hC:       y = a | b;
         4'hD:       y = b;
         4'hE:       y = a & ~b;
         4'hF:       y = ~b;
         default: begin
            case (op)
               4'h2, 4'hA: begin us = ua - ub; ss = sa - sb; end
               4'h3:       begin us = ub - ua; ss = sb - sa; end
               4'h4, 4'hB: begin us = ua + ub; ss = sa + sb; end
               4'h5:       begin us = ua + ub + ci; ss = sa + sb + ci; end
               4'h6:       begin us = ua - ub - (1 - ci); ss = sa - sb - (1 - ci); end
               default:    begin us = ub - ua - (1 - ci); ss = sb - sa - (1 - ci); end
            endcase
            y = us[31:0];
            if (op inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA}) c = (us >= 0);
            else c = (us >= TWO32);
            v = (ss > SMAX) || (ss < SMIN);
         end
      endcase
      return {y[31], (y == 32'h0), c, v, y};
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 4))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic s);
      if (p == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_s = s; end
      else        begin req1_a = a; req1_b = b; req1_op = op; req1_s = s; end
   endtask

   task automatic get_port(input int p, output logic [31:0] a, output logic [31:0] b,
                           output logic [3:0] op, output logic s);
      if (p == 0) begin a = req0_a; b = req0_b; op = req0_op; s = req0_s; end
      else        begin a = req1_a; b = req1_b; op = req1_op; s = req1_s; end
   endtask

   task automatic rand_port(input int p);
      set_port(p, pick_operand(), pick_operand(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
      set_port(0, 32'h0, 32'h0, 4'h0, 1'b0);
      set_port(1, 32'h0, 32'h0, 4'h0, 1'b0);
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rsp_y !== 32'h0) begin failures++; $display("FAIL reset_rsp_y: got %h want 0", rsp_y); end
      checks++; if (rsp_nzcv !== 4'h0) begin failures++; $display("FAIL reset_rsp_nzcv: got %b want 0000", rsp_nzcv); end
      checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
      checks++; if (flags_nzcv !== FLAG_INIT) begin failures++; $display("FAIL reset_flags: got %b want %b", flags_nzcv, FLAG_INIT); end
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      m_flags = FLAG_INIT;
      m_last  = 1'b1;
   endtask

   task automatic test_contention();
      logic [35:0] exp_r;
      logic [31:0] a, b;
      logic [3:0]  op;
      logic        s;
      logic [1:0]  want;
      int          exp_id;
      exp_r = '0; exp_id = 0;
      rsp_ready = 1'b1;
      rand_port(0); rand_port(1);
      @(negedge clk);
      req_valid = 2'b11;
      for (int i = 0; i <= 6; i++) begin
         if (i == 6) req_valid = 2'b00;
         #1;
         if (i > 0) begin
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL cont_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
            checks++; if (rsp_id !== exp_id[0]) begin failures++; $display("FAIL cont_rsp_id[%0d]: got %b want %0d", i, rsp_id, exp_id); end
            checks++; if ({rsp_nzcv, rsp_y} !== exp_r) begin failures++; $display("FAIL cont_result[%0d]: got %h want %h", i, {rsp_nzcv, rsp_y}, exp_r); end
            checks++; if (flags_nzcv !== m_flags) begin failures++; $display("FAIL cont_flags[%0d]: got %b want %b", i, flags_nzcv, m_flags); end
            $display("contention txn %0d: id=%0d y=%h nzcv=%b", i - 1, rsp_id, rsp_y, rsp_nzcv);
         end
         if (i < 6) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_ready !== want) begin failures++; $display("FAIL cont_grant[%0d]: got %b want %b", i, req_ready, want); end
            exp_id = i % 2;
            get_port(exp_id, a, b, op, s);
            exp_r = ref_alu(op, a, b, m_flags[1]);
            if (s) m_flags = exp_r[35:32];
            m_last = exp_id[0];
            @(negedge clk); #1;
            checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL cont_exec[%0d]: req_ready=%b busy=%b want 00/1", i, req_ready, busy); end
            rand_port(exp_id);
         end
         @(negedge clk);
      end
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL cont_idle: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
   endtask

   task automatic test_single_op();
      rsp_ready = 1'b0;
      @(negedge clk);
      set_port(0, 32'd5, 32'd3, 4'b0100, 1'b1);
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant: got %b want 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_exec: rsp_valid=%b busy=%b want 0/1", rsp_valid, busy); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
      checks++; if (rsp_y !== 32'd8) begin failures++; $display("FAIL single_rsp_y: got %h want 8", rsp_y); end
      checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL single_rsp_id: got %b want 0", rsp_id); end
      checks++; if (rsp_nzcv !== 4'b0000) begin failures++; $display("FAIL single_rsp_nzcv: got %b want 0000", rsp_nzcv); end
      checks++; if (flags_nzcv !== 4'b0000) begin failures++; $display("FAIL single_flags: got %b want 0000", flags_nzcv); end
      $display("single txn: id=%0d y=%h nzcv=%b", rsp_id, rsp_y, rsp_nzcv);
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
      rsp_ready = 1'b0;
      m_flags = 4'b0000;
      m_last  = 1'b0;
   endtask

   task automatic test_back_pressure();
      logic [35:0] exp0, exp1;
      rsp_ready = 1'b0;
      @(negedge clk);
      set_port(0, pick_operand(), pick_operand(), 4'b0010, 1'b0);
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant0: got %b want 01", req_ready); end
      exp0 = ref_alu(4'b0010, req0_a, req0_b, m_flags[1]);
      @(negedge clk);
      req_valid = 2'b10;
      set_port(1, pick_operand(), pick_operand(), 4'b1100, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || {rsp_nzcv, rsp_y} !== exp0)
            begin failures++; $display("FAIL bp_hold[%0d]: valid=%b id=%b res=%h want 1/0/%h", k, rsp_valid, rsp_id, {rsp_nzcv, rsp_y}, exp0); end
         checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready[%0d]: got %b want 00", k, req_ready); end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_grant1: got %b want 10", req_ready); end
      exp1 = ref_alu(4'b1100, req1_a, req1_b, m_flags[1]);
      m_flags = exp1[35:32];
      m_last  = 1'b1;
      @(negedge clk);
      req_valid = 2'b00; rsp_ready = 1'b0;
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin failures++; $display("FAIL bp_rsp1: valid=%b id=%b want 1/1", rsp_valid, rsp_id); end
      checks++; if ({rsp_nzcv, rsp_y} !== exp1) begin failures++; $display("FAIL bp_result1: got %h want %h", {rsp_nzcv, rsp_y}, exp1); end
      checks++; if (flags_nzcv !== m_flags) begin failures++; $display("FAIL bp_flags: got %b want %b", flags_nzcv, m_flags); end
      $display("back-pressure txn: id=%0d y=%h nzcv=%b", rsp_id, rsp_y, rsp_nzcv);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_carry_chain();
      rsp_ready = 1'b1;
      @(negedge clk);
      set_port(0, 32'hFFFF_FFFF, 32'h1, 4'b0100, 1'b1);
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL carry_grant0: got %b want 01", req_ready); end
      @(negedge clk);
      set_port(0, 32'h0, 32'h0, 4'b0101, 1'b0);
      @(negedge clk); #1;
      checks++; if (rsp_y !== 32'h0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL carry_add_y: y=%h valid=%b want 0/1", rsp_y, rsp_valid); end
      checks++; if (flags_nzcv !== 4'b0110) begin failures++; $display("FAIL carry_add_flags: got %b want 0110", flags_nzcv); end
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL carry_b2b_grant: got %b want 01", req_ready); end
      $display("carry txn ADD: y=%h flags=%b", rsp_y, flags_nzcv);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk); #1;
      checks++; if (rsp_y !== 32'h1) begin failures++; $display("FAIL carry_adc_y: got %h want 1", rsp_y); end
      checks++; if (rsp_nzcv !== 4'b0000) begin failures++; $display("FAIL carry_adc_nzcv: got %b want 0000", rsp_nzcv); end
      checks++; if (flags_nzcv !== 4'b0110) begin failures++; $display("FAIL carry_adc_flags: got %b want 0110", flags_nzcv); end
      $display("carry txn ADC: y=%h flags=%b", rsp_y, flags_nzcv);
      @(negedge clk);
      rsp_ready = 1'b0;
      m_flags = 4'b0110;
      m_last  = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      logic [35:0] exp_r;
      rsp_ready = 1'b1;
      @(negedge clk);
      set_port(0, 32'h0, 32'h1, 4'b0010, 1'b1);
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_grant: got %b want 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_exec_busy: got %b want 1", busy); end
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL rst_async_ctrl: busy=%b valid=%b ready=%b", busy, rsp_valid, req_ready); end
      checks++; if (rsp_y !== 32'h0 || rsp_nzcv !== 4'h0 || rsp_id !== 1'b0) begin failures++; $display("FAIL rst_async_rsp: y=%h nzcv=%b id=%b", rsp_y, rsp_nzcv, rsp_id); end
      checks++; if (flags_nzcv !== FLAG_INIT) begin failures++; $display("FAIL rst_async_flags: got %b want %b", flags_nzcv, FLAG_INIT); end
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      m_flags = FLAG_INIT;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         checks++; if (rsp_valid !== 1'b0 || flags_nzcv !== FLAG_INIT) begin failures++; $display("FAIL rst_no_rsp[%0d]: valid=%b flags=%b", k, rsp_valid, flags_nzcv); end
      end
      @(negedge clk);
      rand_port(0); rand_port(1);
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
      exp_r = ref_alu(req0_op, req0_a, req0_b, m_flags[1]);
      if (req0_s) m_flags = exp_r[35:32];
      m_last = 1'b0;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || {rsp_nzcv, rsp_y} !== exp_r)
         begin failures++; $display("FAIL rst_after_rsp: valid=%b id=%b res=%h want 1/0/%h", rsp_valid, rsp_id, {rsp_nzcv, rsp_y}, exp_r); end
      checks++; if (flags_nzcv !== m_flags) begin failures++; $display("FAIL rst_after_flags: got %b want %b", flags_nzcv, m_flags); end
      $display("post-reset txn: id=%0d y=%h nzcv=%b", rsp_id, rsp_y, rsp_nzcv);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      logic        pend;
      int          age, g;
      logic [35:0] pexp;
      logic        pid;
      logic [3:0]  flags_prev;
      logic [1:0]  want, drop;
      logic [31:0] a, b;
      logic [3:0]  op;
      logic        s;
      pend = 1'b0; age = 0; pexp = '0; pid = 1'b0; flags_prev = m_flags; drop = 2'b00; g = -1;
      req_valid = 2'b00;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         req_valid = req_valid & ~drop;
         drop = 2'b00;
         for (int p = 0; p < 2; p++)
            if (!req_valid[p] && $urandom_range(0, 1) == 1) begin rand_port(p); req_valid[p] = 1'b1; end
         if (cyc >= 380) req_valid = 2'b00;
         rsp_ready = ($urandom_range(0, 3) != 0) || (cyc >= 380);
         #1;
         checks++; if (rsp_valid !== (pend && age >= 2)) begin failures++; $display("FAIL rand_rsp_valid[%0d]: got %b want %b", cyc, rsp_valid, (pend && age >= 2)); end
         if (pend && age >= 2) begin
            checks++; if ({rsp_nzcv, rsp_y} !== pexp || rsp_id !== pid)
               begin failures++; $display("FAIL rand_result[%0d]: got id=%b %h want id=%b %h", cyc, rsp_id, {rsp_nzcv, rsp_y}, pid, pexp); end
         end
         checks++; if (flags_nzcv !== ((pend && age < 2) ? flags_prev : m_flags))
            begin failures++; $display("FAIL rand_flags[%0d]: got %b", cyc, flags_nzcv); end
         want = 2'b00; g = -1;
         if (!pend || (age >= 2 && rsp_ready)) begin
            if (req_valid == 2'b11) g = m_last ? 0 : 1;
            else if (req_valid == 2'b01) g = 0;
            else if (req_valid == 2'b10) g = 1;
            if (g >= 0) want = (g == 1) ? 2'b10 : 2'b01;
         end
         checks++; if (req_ready !== want) begin failures++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, req_ready, want); end
         if (pend && age >= 2 && rsp_ready) begin
            $display("random txn: id=%0d y=%h nzcv=%b flags=%b", rsp_id, rsp_y, rsp_nzcv, flags_nzcv);
            pend = 1'b0;
         end
         if (g >= 0) begin
            get_port(g, a, b, op, s);
            flags_prev = m_flags;
            pexp = ref_alu(op, a, b, m_flags[1]);
            if (s) m_flags = pexp[35:32];
            pid = g[0]; m_last = g[0];
            pend = 1'b1; age = 0;
            drop = want;
         end
         if (pend) age++;
      end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rand_drain: valid=%b busy=%b want 0/0", rsp_valid, busy); end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_op();
      test_back_pressure();
      test_carry_chain();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/arm_alu_scheduler.md
# arm_alu_scheduler

Shares the single `arm_alu` instance between two requesters (port 0: execute stage, port 1: auxiliary/address unit) using round-robin arbitration and valid/ready handshakes. It registers operands, sequences one ALU operation at a time through a 3-state FSM, and returns the registered result and flags. It owns the architectural NZCV flag register and feeds its C bit to the ALU as `C_in`.

## Interface
- `FLAG_INIT`, 4'b0000: NZCV value loaded into the flag register on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit i means requester i presents an operation.
- `req_ready` out 2: bit i means requester i's operation is accepted this cycle. One-hot or zero.
- `req0_a`, `req1_a` in 32: operand A (ALU `regA`).
- `req0_b`, `req1_b` in 32: operand B (ALU `regB`).
- `req0_op`, `req1_op` in 4: ALU opcode (ALU `A` input, ARM data-processing encoding).
- `req0_s`, `req1_s` in 1: set-flags; when 1, the result updates the flag register.
- `rsp_valid` out 1: a result is held.
- `rsp_ready` in 1: the consumer takes the result.
- `rsp_id` out 1: requester index that owns the result.
- `rsp_y` out 32: registered ALU `Y`.
- `rsp_nzcv` out 4: registered ALU {N,Z,C,V} for this op, whatever the value of s.
- `flags_nzcv` out 4: architectural flag register.
- `busy` out 1: high in EXEC or DONE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any `req_valid` is set, grant one requester g. Assert `req_ready[g]` combinationally in the same cycle.
  - Latch g's a, b, op and s, plus id = g, into the operand registers. Next state is EXEC.
  - With no request, stay in IDLE.
- EXEC:
  - Drive `arm_alu` from the operand registers, with `C_in` = `flags_nzcv[1]` (current C).
  - At the clock edge, capture `Y` into `rsp_y`, {N,Z,C,V} into `rsp_nzcv`, and the latched id into `rsp_id`.
  - If s = 1, also load `flags_nzcv` with {N,Z,C,V}. If s = 0, the flag register is unchanged.
  - Next state is DONE. EXEC always lasts exactly one cycle.
- DONE:
  - `rsp_valid` = 1. Hold all `rsp_*` outputs stable while `rsp_ready` = 0.
  - On `rsp_ready` = 1 with some `req_valid` set: grant and latch as in IDLE (`req_ready` asserts this cycle). Next state is EXEC (back-to-back).
  - On `rsp_ready` = 1 with no request: next state is IDLE.
- `req_ready` is 0 in EXEC, and in DONE while `rsp_ready` = 0. `req_ready` depends combinationally on `req_valid` and `rsp_ready`.
- Round-robin arbitration:
  - The `last` register resets to 1, so requester 0 wins the first contention.
  - If both request, grant `~last`. If one requests, grant it.
  - On every grant, `last` takes the granted index.
- Requesters must hold their inputs stable while `req_valid` is set and `req_ready` is not. The block samples only on the grant cycle.

## Timing
- Reset values (async, immediate):
  - state = IDLE, `last` = 1.
  - `req_ready` = 0, `rsp_valid` = 0, `busy` = 0.
  - `rsp_y` = 0, `rsp_nzcv` = 0, `rsp_id` = 0.
  - `flags_nzcv` = `FLAG_INIT`.
  - Operand registers = 0.
- Latency: grant at edge k, EXEC during cycle k+1, `rsp_valid` high from edge k+2. Two cycles from request to response.
- Throughput: one op per 2 cycles with `rsp_ready` held at 1.
- A flag update from op n is visible as `C_in` to op n+1, including back-to-back.
- Reset asserted in EXEC or DONE discards the in-flight op: no response, and the flags are not updated by it.
- `rsp_valid` never drops without a `rsp_ready` handshake, except on reset.

## Test plan
- Single op: port 0 sends op ADD (4'b0100), a = 5, b = 3, s = 1. Expect `req_ready` = 2'b01 in that cycle, then `rsp_valid` 2 cycles later with `rsp_y` = 8, `rsp_id` = 0, `rsp_nzcv` = 4'b0000, `flags_nzcv` = 4'b0000.
- Contention: both ports hold `req_valid` with `rsp_ready` = 1 for 6 ops. Expect grants in the order 0,1,0,1,0,1, `rsp_id` matching, and a result every 2 cycles.
- Back-pressure: hold `rsp_ready` = 0 for 5 cycles in DONE while port 1 requests. Expect `rsp_y`/`rsp_id` stable and `req_ready` = 0. Port 1 is granted in the same cycle `rsp_ready` rises.
- Carry chain:
  - ADD 0xFFFFFFFF + 1 with s = 1: expect `rsp_y` = 0 and `flags_nzcv` = 4'b0110.
  - Then ADC (4'b0101) 0 + 0 with s = 0: expect `rsp_y` = 1 and `flags_nzcv` unchanged at 4'b0110.
- Reset mid-op: assert `reset_n` = 0 during EXEC of an s = 1 op. Expect all outputs at reset values immediately, `flags_nzcv` = `FLAG_INIT`, no response after release, and requester 0 granted first afterwards.
